// File: rtl/framebuffer_clear.sv
// Purpose: fill one framebuffer in SDRAM with a single colour using Avalon-MM burst writes.
// Latency: write rises the cycle after an accepted start; done pulses the cycle after the final beat.
// Backpressure: waitrequest freezes address/burstcount/writedata; beats advance only when accepted.
module framebuffer_clear #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter logic [28:0] BASE_ADDR0 = 29'h0400000,
  parameter logic [28:0] BASE_ADDR1 = 29'h0500000,
  parameter int          BURST_LEN  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        buffer,
  input  logic [31:0] colour,
  output logic        busy,
  output logic        done,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  output logic [63:0] writedata,
  output logic [7:0]  byteenable,
  output logic        write,
  input  logic        waitrequest
);

  // Two pixels per 64-bit word.
  localparam int TOTAL = (H_RES * V_RES) / 2;
  // At least 9 bits so that BURST_LEN (up to 128) always fits alongside the word count.
  localparam int REM_W = ($clog2(TOTAL + 1) > 9) ? $clog2(TOTAL + 1) : 9;
  localparam logic [REM_W-1:0] TOTAL_R = REM_W'(TOTAL);
  localparam logic [REM_W-1:0] BL_R    = REM_W'(BURST_LEN);
  localparam logic [7:0]       BL_8    = 8'(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Size of the next burst: a full burst, or whatever is left if that is smaller.
  function automatic logic [7:0] burst_size(input logic [REM_W-1:0] rem);
    if (rem >= BL_R) begin
      burst_size = BL_8;
    end else begin
      burst_size = rem[7:0];
    end
  endfunction

  state_t           state_q, state_d;
  logic [REM_W-1:0] remaining_q, remaining_d;
  logic [28:0]      base_q, base_d;
  logic [7:0]       bc_q, bc_d;
  logic [7:0]       beat_q, beat_d;
  logic [31:0]      colour_q, colour_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_beat;
  logic [REM_W-1:0] rem_after;

  // Next-state logic: start latching in IDLE, beat/burst bookkeeping in BURST.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    base_d      = base_q;
    bc_d        = bc_q;
    beat_d      = beat_q;
    colour_d    = colour_q;
    done_d      = 1'b0;

    accept    = (state_q == BURST) && !waitrequest;
    last_beat = (beat_q == (bc_q - 8'd1));
    rem_after = remaining_q - {{(REM_W-8){1'b0}}, bc_q};

    case (state_q)
      IDLE: begin
        // The done cycle still counts as busy for the purpose of ignoring start.
        if (start && !done_q) begin
          state_d     = BURST;
          colour_d    = colour;
          base_d      = buffer ? BASE_ADDR1 : BASE_ADDR0;
          remaining_d = TOTAL_R;
          bc_d        = burst_size(TOTAL_R);
          beat_d      = 8'd0;
        end
      end
      BURST: begin
        if (accept) begin
          if (last_beat) begin
            // Burst finished: move the window on; address wraps at 29 bits.
            remaining_d = rem_after;
            base_d      = base_q + {21'b0, bc_q};
            beat_d      = 8'd0;
            if (rem_after == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
              bc_d    = 8'd0;
            end else begin
              bc_d = burst_size(rem_after);
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; async reset drops the write strobe immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      base_q      <= '0;
      bc_q        <= '0;
      beat_q      <= '0;
      colour_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      base_q      <= base_d;
      bc_q        <= bc_d;
      beat_q      <= beat_d;
      colour_q    <= colour_d;
      done_q      <= done_d;
    end
  end

  // Avalon outputs come straight from registers and are zeroed whenever no write is pending.
  always_comb begin
    write      = (state_q == BURST);
    busy       = write;
    done       = done_q;
    address    = write ? base_q : 29'd0;
    burstcount = write ? bc_q : 8'd0;
    writedata  = write ? {colour_q, colour_q} : 64'd0;
    byteenable = write ? 8'hFF : 8'h00;
  end

endmodule

// File: tb/tb_framebuffer_clear.sv
// Bench for framebuffer_clear: 20x5 frame (50 words) with 16-beat bursts, so the last burst is short.
// Buffer 1 sits near the top of the 29-bit space so its clear wraps the address.
// Hand-written vectors for start/stall/done corners, then randomized traffic against a word-index model.
module tb_framebuffer_clear;

  localparam int          H     = 20;
  localparam int          V     = 5;
  localparam int          BL    = 16;
  localparam int          TOTAL = (H * V) / 2;
  localparam logic [28:0] B0    = 29'h0400000;
  localparam logic [28:0] B1    = 29'h1FFFFFF0;

  logic        clock;
  logic        reset;
  logic        start;
  logic        buffer;
  logic [31:0] colour;
  logic        busy;
  logic        done;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        write;
  logic        waitrequest;

  framebuffer_clear #(
    .H_RES(H), .V_RES(V), .BASE_ADDR0(B0), .BASE_ADDR1(B1), .BURST_LEN(BL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .buffer(buffer), .colour(colour),
    .busy(busy), .done(done), .address(address), .burstcount(burstcount),
    .writedata(writedata), .byteenable(byteenable), .write(write),
    .waitrequest(waitrequest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a clear is just "word idx of TOTAL"; the bus view is derived from idx.
  bit          m_active;
  bit          m_done;
  int          idx;
  logic [28:0] m_base;
  logic [31:0] m_col;
  int          clears;
  int          dut_beats;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [28:0] exp_addr();
    int first;
    first = (idx / BL) * BL;
    return m_base + 29'(first);
  endfunction

  function automatic logic [7:0] exp_bc();
    int left;
    left = TOTAL - (idx / BL) * BL;
    return (left < BL) ? 8'(left) : 8'(BL);
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_done    = 1'b0;
    idx       = 0;
    dut_beats = 0;
  endtask

  task automatic check_model();
    chk("busy", {63'd0, busy}, {63'd0, m_active});
    chk("write", {63'd0, write}, {63'd0, m_active});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("byteenable", {56'd0, byteenable}, m_active ? 64'hFF : 64'h00);
    if (m_active) begin
      chk("address", {35'd0, address}, {35'd0, exp_addr()});
      chk("burstcount", {56'd0, burstcount}, {56'd0, exp_bc()});
      chk("writedata", writedata, {m_col, m_col});
    end
  endtask

  // One clock: drive inputs, advance the model by the edge, compare DUT to model.
  task automatic step(input bit st, input bit bf, input logic [31:0] col, input bit wr);
    bit nd;
    start       = st;
    buffer      = bf;
    colour      = col;
    waitrequest = wr;
    if (write && !waitrequest) dut_beats++;
    @(posedge clock);
    #1;
    nd = 1'b0;
    if (m_active) begin
      if (!wr) begin
        idx++;
        if (idx == TOTAL) begin
          m_active = 1'b0;
          nd       = 1'b1;
          clears++;
        end
      end
    end else if (st && !m_done) begin
      m_active = 1'b1;
      idx      = 0;
      m_base   = bf ? B1 : B0;
      m_col    = col;
    end
    m_done = nd;
    check_model();
    if (done) begin
      chk("beats_per_clear", 64'(dut_beats), 64'(TOTAL));
      dut_beats = 0;
    end
  endtask

  typedef struct {
    bit          st;
    bit          bf;
    logic [31:0] col;
    bit          wr;
    bit          e_busy;
    bit          e_write;
    logic [28:0] e_addr;
    logic [7:0]  e_bc;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;

    // Idle, start, stall with colour change, start while busy, one more beat.
    tbl[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 29'h0,       8'd0,  32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h00FF0000, 1'b0, 1'b1, 1'b1, 29'h0400000, 8'd16, 32'h00FF0000};
    tbl[2] = '{1'b0, 1'b0, 32'h00ABCDEF, 1'b1, 1'b1, 1'b1, 29'h0400000, 8'd16, 32'h00FF0000};
    tbl[3] = '{1'b1, 1'b1, 32'h00ABCDEF, 1'b0, 1'b1, 1'b1, 29'h0400000, 8'd16, 32'h00FF0000};
    tbl[4] = '{1'b0, 1'b0, 32'h00ABCDEF, 1'b0, 1'b1, 1'b1, 29'h0400000, 8'd16, 32'h00FF0000};

    clears      = 0;
    model_reset();
    m_base      = '0;
    m_col       = '0;
    reset       = 1'b1;
    start       = 1'b0;
    buffer      = 1'b0;
    colour      = '0;
    waitrequest = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_write", {63'd0, write}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_address", {35'd0, address}, 64'd0);
    chk("reset_burstcount", {56'd0, burstcount}, 64'd0);
    chk("reset_writedata", writedata, 64'd0);
    chk("reset_byteenable", {56'd0, byteenable}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step(tbl[i].st, tbl[i].bf, tbl[i].col, tbl[i].wr);
      chk($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].e_busy});
      chk($sformatf("vec%0d_write", i), {63'd0, write}, {63'd0, tbl[i].e_write});
      if (tbl[i].e_write) begin
        chk($sformatf("vec%0d_address", i), {35'd0, address}, {35'd0, tbl[i].e_addr});
        chk($sformatf("vec%0d_burstcount", i), {56'd0, burstcount}, {56'd0, tbl[i].e_bc});
        chk($sformatf("vec%0d_writedata", i), writedata, {tbl[i].e_wd, tbl[i].e_wd});
      end
    end

    // Run the first clear to completion; the final burst is 2 beats at +48.
    n = 0;
    while (!done && n < 100) begin
      if (write && burstcount == 8'd2) begin
        chk("last_burst_addr", {35'd0, address}, {35'd0, 29'h0400030});
      end
      step(1'b0, 1'b0, 32'h00777777, 1'b0);
      n++;
    end
    chk("first_clear_done", {63'd0, done}, 64'd1);

    // Start on the done cycle is ignored; start the cycle after begins a clear.
    step(1'b1, 1'b1, 32'h00112233, 1'b0);
    chk("start_on_done_ignored", {63'd0, busy}, 64'd0);
    step(1'b1, 1'b1, 32'h00112233, 1'b0);
    chk("restart_write", {63'd0, write}, 64'd1);
    chk("restart_address", {35'd0, address}, {35'd0, B1});

    // Buffer 1 under random stalls and a changing colour input; address wraps past 2^29.
    n = 0;
    while (!done && n < 400) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      n++;
    end
    chk("stall_clear_done", {63'd0, done}, 64'd1);

    // Reset in the middle of a burst (while beat 3 is on the bus).
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h00C0FFEE, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("midreset_write", {63'd0, write}, 64'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_done", {63'd0, done}, 64'd0);
    chk("midreset_address", {35'd0, address}, 64'd0);
    start = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic: occasional starts, 50% stalls, random colour/buffer every cycle.
    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)));
    end
    chk("random_clears_completed", {63'd0, (clears >= 4)}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
